// File: rtl/ifu_pkg.sv
// Shared IFU definitions: datapath width, default reset PC, ISA constants
// and the {pc, instr} layout of an instruction buffer entry.
package ifu_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } ibuf_ent_t;

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] a);
    return {a[XLEN-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/ifu_fifo.sv
// Synchronous instruction buffer with flush; push and pop on a full buffer
// in the same cycle is legal. Read data is the registered head entry.
module ifu_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_dat,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dat,
  output logic             o_empty,
  output logic [CW-1:0]    o_cnt
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr;
  logic [PW-1:0]    r_rd;
  logic [CW-1:0]    r_cnt;
  logic             w_full;
  logic             w_push;
  logic             w_pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_full  = (r_cnt == CW'(DEPTH));
  assign w_pop   = i_pop & (r_cnt != '0);
  assign w_push  = i_push & (~w_full | w_pop);
  assign o_dat   = r_mem[r_rd];
  assign o_empty = (r_cnt == '0);
  assign o_cnt   = r_cnt;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else if (i_flush) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= nxt(r_wr);
      if (w_pop)  r_rd <= nxt(r_rd);
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !i_flush) r_mem[r_wr] <= i_dat;
  end
endmodule

// File: rtl/ifu.sv
// Instruction fetch unit: credit-limited in-order fetch into a small buffer,
// with redirect flush that drops responses still in flight from the old path.
module ifu
  import ifu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int              BUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_b,
  output logic            ifu_req_valid,
  input  logic            ifu_req_ready,
  output logic [XLEN-1:0] ifu_req_addr,
  input  logic            ifu_rsp_valid,
  input  logic [31:0]     ifu_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_instr_valid,
  input  logic            if_instr_ready,
  output logic [31:0]     if_instr,
  output logic [XLEN-1:0] if_pc
);
  localparam int CW = $clog2(BUF_DEPTH + 1);

  logic [XLEN-1:0] r_fpc;
  logic [XLEN-1:0] r_rsp_pc;
  logic [CW-1:0]   r_outst;
  logic [CW-1:0]   r_drop;
  logic [CW-1:0]   w_buf_cnt;
  logic [CW:0]     w_inflight;
  logic            w_fire;
  logic            w_push;
  logic            w_pop;
  logic            w_empty;
  ibuf_ent_t       w_push_ent;
  ibuf_ent_t       w_head;

  // Outstanding plus buffered never exceeds the buffer size, so every response has a slot.
  assign w_inflight    = {1'b0, r_outst} + {1'b0, w_buf_cnt};
  assign ifu_req_valid = rst_b & ~redirect_valid & (w_inflight < (CW+1)'(BUF_DEPTH));
  assign ifu_req_addr  = align_pc(r_fpc);
  assign w_fire        = ifu_req_valid & ifu_req_ready;
  assign w_push        = ifu_rsp_valid & (r_drop == '0) & ~redirect_valid;
  assign w_pop         = if_instr_valid & if_instr_ready & ~redirect_valid;
  assign w_push_ent    = '{pc: r_rsp_pc, instr: ifu_rsp_data};

  assign if_instr_valid = ~w_empty;
  assign if_instr       = w_empty ? '0 : w_head.instr;
  assign if_pc          = w_empty ? '0 : w_head.pc;

  ifu_fifo #(
    .WIDTH($bits(ibuf_ent_t)),
    .DEPTH(BUF_DEPTH)
  ) u_buf (
    .clk    (clk),
    .rst_b  (rst_b),
    .i_flush(redirect_valid),
    .i_push (w_push),
    .i_dat  (w_push_ent),
    .i_pop  (w_pop),
    .o_dat  (w_head),
    .o_empty(w_empty),
    .o_cnt  (w_buf_cnt)
  );

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_fpc    <= RESET_PC;
      r_rsp_pc <= RESET_PC;
      r_outst  <= '0;
      r_drop   <= '0;
    end else begin
      r_outst <= r_outst + CW'(w_fire) - CW'(ifu_rsp_valid);
      if (redirect_valid) begin
        r_fpc    <= align_pc(redirect_pc);
        r_rsp_pc <= align_pc(redirect_pc);
        // Everything still in flight after this cycle's response belongs to the old path.
        r_drop   <= r_outst - CW'(ifu_rsp_valid);
      end else begin
        if (w_fire) r_fpc <= r_fpc + XLEN'(4);
        if (w_push) r_rsp_pc <= r_rsp_pc + XLEN'(4);
        if (ifu_rsp_valid && r_drop != '0) r_drop <= r_drop - CW'(1);
      end
    end
  end
endmodule
